// File: rtl/mac_acu_16.sv
// -----------------------------------------------------------------------------
// mac_acu_16
//   Accumulates a block of n_terms unsigned products coming from the 16x16
//   sequential multiplier. The sum saturates instead of wrapping. Each finished
//   sum is offered on a valid/ready result port.
//
//   The multiplier cannot be stalled. While a result is waiting, a single
//   pending register catches one product. Any further product that arrives in
//   that time is discarded, and the sticky drop flag is set.
//
// Parameters
//   PROD_W : product width
//   ACC_W  : accumulator / result width (>= PROD_W)
//   CNT_W  : term-counter width (n_terms == 0 means 2^CNT_W terms)
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   done       : one-cycle pulse, product valid this cycle
//   product    : unsigned product, sampled when done=1
//   n_terms    : products per result
//   clr        : synchronous flush of block, pending product, result and drop
//   res_valid  : result available
//   res_data   : accumulated (saturated) sum
//   res_ovf    : saturation happened inside this result
//   res_ready  : consumer accepts result when res_valid & res_ready
//   term_cnt   : products accumulated so far in the current block
//   drop       : sticky, a product was discarded
// -----------------------------------------------------------------------------
module mac_acu_16 #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [PROD_W-1:0] product,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              clr,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              drop
);

  typedef enum logic {ACUM = 1'b0, SALIDA = 1'b1} state_t;

  state_t              state_reg,     state_next;
  logic [ACC_W-1:0]    acc_reg,       acc_next;
  logic [CNT_W-1:0]    term_cnt_reg,  term_cnt_next;
  logic                ovf_blk_reg,   ovf_blk_next;
  logic                res_valid_reg, res_valid_next;
  logic [ACC_W-1:0]    res_data_reg,  res_data_next;
  logic                res_ovf_reg,   res_ovf_next;
  logic                pend_v_reg,    pend_v_next;
  logic [PROD_W-1:0]   pend_reg,      pend_next;
  logic                drop_reg,      drop_next;

  // Datapath for a take. A waiting pending product always goes first, so
  // products are accumulated in the order they arrived.
  logic              take;
  logic [PROD_W-1:0] src;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  sum_sat;
  logic              sum_carry;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_term;

  assign take      = pend_v_reg | done;
  assign src       = pend_v_reg ? pend_reg : product;
  assign sum_wide  = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, src};
  assign sum_carry = sum_wide[ACC_W];
  assign sum_sat   = sum_carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  // Comparison is done in CNT_W bits. With n_terms == 0, the block therefore
  // ends after 2^CNT_W terms.
  assign cnt_inc   = term_cnt_reg + 1'b1;
  assign last_term = (cnt_inc == n_terms);

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    term_cnt_next  = term_cnt_reg;
    ovf_blk_next   = ovf_blk_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    res_ovf_next   = res_ovf_reg;
    pend_v_next    = pend_v_reg;
    pend_next      = pend_reg;
    drop_next      = drop_reg;

    case (state_reg)
      ACUM: begin
        // Draining the pending product frees the slot. A product that
        // arrives in the same cycle refills it.
        if (pend_v_reg) begin
          pend_v_next = done;
          if (done) pend_next = product;
        end
        if (take) begin
          if (last_term) begin
            res_data_next  = sum_sat;
            res_ovf_next   = ovf_blk_reg | sum_carry;
            res_valid_next = 1'b1;
            acc_next       = '0;
            term_cnt_next  = '0;
            ovf_blk_next   = 1'b0;
            state_next     = SALIDA;
          end else begin
            acc_next      = sum_sat;
            term_cnt_next = cnt_inc;
            ovf_blk_next  = ovf_blk_reg | sum_carry;
          end
        end
      end

      SALIDA: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = ACUM;
        end
        // The multiplier cannot wait, so the product is either parked or lost.
        if (done) begin
          if (!pend_v_reg) begin
            pend_next   = product;
            pend_v_next = 1'b1;
          end else begin
            drop_next = 1'b1;
          end
        end
      end

      default: state_next = ACUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_reg     <= ACUM;
      acc_reg       <= '0;
      term_cnt_reg  <= '0;
      ovf_blk_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_ovf_reg   <= 1'b0;
      pend_v_reg    <= 1'b0;
      pend_reg      <= '0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      term_cnt_reg  <= term_cnt_next;
      ovf_blk_reg   <= ovf_blk_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_ovf_reg   <= res_ovf_next;
      pend_v_reg    <= pend_v_next;
      pend_reg      <= pend_next;
      drop_reg      <= drop_next;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_ovf   = res_ovf_reg;
  assign term_cnt  = term_cnt_reg;
  assign drop      = drop_reg;

endmodule

// File: tb/tb_mac_acu_16.sv
// -----------------------------------------------------------------------------
// tb_mac_acu_16
//   Directed, table-driven bench for mac_acu_16 (ACC_W = 32 so that
//   saturation is reachable with 32-bit products). Each record is one clock
//   cycle: the inputs to apply and the outputs expected after the edge.
// -----------------------------------------------------------------------------
module tb_mac_acu_16;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              done;
  logic [PROD_W-1:0] product;
  logic [CNT_W-1:0]  n_terms;
  logic              clr;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic              res_ready;
  logic [CNT_W-1:0]  term_cnt;
  logic              drop;

  always #5 clk = ~clk;

  mac_acu_16 #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .product   (product),
    .n_terms   (n_terms),
    .clr       (clr),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_ready (res_ready),
    .term_cnt  (term_cnt),
    .drop      (drop)
  );

  typedef struct {
    logic        done;
    logic [31:0] prod;
    logic [7:0]  n;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [7:0]  exp_cnt;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic d, input logic [31:0] p, input logic [7:0] n,
                     input logic rdy, input logic c, input logic ev,
                     input logic [31:0] ed, input logic eo, input logic [7:0] ec,
                     input logic edr);
    vec_t v;
    v.done = d; v.prod = p; v.n = n; v.ready = rdy; v.clr = c;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ovf = eo; v.exp_cnt = ec; v.exp_drop = edr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                           input logic eo, input logic [7:0] ec, input logic edr);
    chk({tag, ".res_valid"}, {31'b0, res_valid}, {31'b0, ev});
    chk({tag, ".res_data"},  res_data,           ed);
    chk({tag, ".res_ovf"},   {31'b0, res_ovf},   {31'b0, eo});
    chk({tag, ".term_cnt"},  {24'b0, term_cnt},  {24'b0, ec});
    chk({tag, ".drop"},      {31'b0, drop},      {31'b0, edr});
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; product = '0; n_terms = 8'd3; clr = 1'b0; res_ready = 1'b1;

    // Reset held for two cycles.
    step; step;
    check_all("reset", 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    $display("reset: valid=%0b data=%0d cnt=%0d drop=%0b", res_valid, res_data, term_cnt, drop);
    rst = 1'b0;

    //   done prod          n  rdy clr | valid data          ovf cnt drop
    // Basic accumulation 10+20+30.
    add(1, 32'd10,        3, 1, 0,    0, 32'd0,          0, 1, 0);
    add(0, 32'd0,         3, 1, 0,    0, 32'd0,          0, 1, 0);
    add(1, 32'd20,        3, 1, 0,    0, 32'd0,          0, 2, 0);
    add(0, 32'd0,         3, 1, 0,    0, 32'd0,          0, 2, 0);
    add(1, 32'd30,        3, 1, 0,    1, 32'd60,         0, 0, 0);
    add(0, 32'd0,         3, 1, 0,    0, 32'd60,         0, 0, 0);
    // Saturation, then a clean block (its first product lands in pend
    // during the handshake cycle).
    add(1, 32'hFFFF_FFFF, 2, 1, 0,    0, 32'd60,         0, 1, 0);
    add(1, 32'd2,         2, 1, 0,    1, 32'hFFFF_FFFF,  1, 0, 0);
    add(1, 32'd1,         2, 1, 0,    0, 32'hFFFF_FFFF,  1, 0, 0);
    add(0, 32'd0,         2, 1, 0,    0, 32'hFFFF_FFFF,  1, 1, 0);
    add(1, 32'd1,         2, 1, 0,    1, 32'd2,          0, 0, 0);
    add(0, 32'd0,         2, 1, 0,    0, 32'd2,          0, 0, 0);
    // Backpressure: 5 held, 7 pending, 9 dropped.
    add(1, 32'd5,         1, 0, 0,    1, 32'd5,          0, 0, 0);
    add(1, 32'd7,         1, 0, 0,    1, 32'd5,          0, 0, 0);
    add(1, 32'd9,         1, 0, 0,    1, 32'd5,          0, 0, 1);
    add(0, 32'd0,         1, 1, 0,    0, 32'd5,          0, 0, 1);
    add(0, 32'd0,         1, 1, 0,    1, 32'd7,          0, 0, 1);
    add(0, 32'd0,         1, 1, 0,    0, 32'd7,          0, 0, 1);
    // clr mid-block (coincident done ignored), then 1+2+3+4.
    add(1, 32'd1,         4, 1, 0,    0, 32'd7,          0, 1, 1);
    add(1, 32'd1,         4, 1, 0,    0, 32'd7,          0, 2, 1);
    add(1, 32'd99,        4, 1, 1,    0, 32'd0,          0, 0, 0);
    add(1, 32'd1,         4, 1, 0,    0, 32'd0,          0, 1, 0);
    add(1, 32'd2,         4, 1, 0,    0, 32'd0,          0, 2, 0);
    add(1, 32'd3,         4, 1, 0,    0, 32'd0,          0, 3, 0);
    add(1, 32'd4,         4, 1, 0,    1, 32'd10,         0, 0, 0);
    add(0, 32'd0,         4, 1, 0,    0, 32'd10,         0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      done = vecs[i].done; product = vecs[i].prod; n_terms = vecs[i].n;
      res_ready = vecs[i].ready; clr = vecs[i].clr;
      step;
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                vecs[i].exp_ovf, vecs[i].exp_cnt, vecs[i].exp_drop);
      $display("vec %0d: done=%0b prod=0x%0h n=%0d rdy=%0b clr=%0b -> valid=%0b data=0x%0h ovf=%0b cnt=%0d drop=%0b",
               i, vecs[i].done, vecs[i].prod, vecs[i].n, vecs[i].ready, vecs[i].clr,
               res_valid, res_data, res_ovf, term_cnt, drop);
    end
    done = 1'b0; clr = 1'b0;

    // rst while in SALIDA with a pending product: both must vanish.
    n_terms = 8'd1; res_ready = 1'b0;
    done = 1'b1; product = 32'd5; step;
    chk("rsts.valid_before", {31'b0, res_valid}, 32'd1);
    done = 1'b1; product = 32'd6; step;
    done = 1'b1; product = 32'd8; rst = 1'b1; step;
    rst = 1'b0; done = 1'b0;
    check_all("rsts.after_rst", 1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    n_terms = 8'd2; res_ready = 1'b1;
    step;
    chk("rsts.no_drain.cnt", {24'b0, term_cnt}, 32'd0);
    chk("rsts.no_drain.valid", {31'b0, res_valid}, 32'd0);
    done = 1'b1; product = 32'd3; step;
    chk("rsts.blk.cnt1", {24'b0, term_cnt}, 32'd1);
    done = 1'b1; product = 32'd4; step;
    done = 1'b0;
    check_all("rsts.blk.result", 1'b1, 32'd7, 1'b0, 8'd0, 1'b0);
    $display("rst-in-SALIDA block: valid=%0b data=%0d", res_valid, res_data);
    step;
    chk("rsts.blk.accepted", {31'b0, res_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
